// File: rtl/fp_add_sub_pipe.sv
// rtl/fp_add_sub_pipe.sv - 3-stage pipelined floating-point adder/subtractor
// FP_ADDSUB_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncate and saturate on overflow.
module fp_add_sub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       a,
  input  logic [EXP_W+MAN_W:0]       b,
  input  logic                       add_sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       res,
  output logic [2:0]                 flags
);
  localparam int W         = 1 + EXP_W + MAN_W;
  localparam int SW        = MAN_W + 4;
  localparam int XW        = EXP_W + 2;
  localparam int ALIGN_MAX = MAN_W + 3;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [XW-1:0]    ONE     = 1;

  typedef struct packed {
    logic             nan;
    logic             inf;
    logic             inf_sign;
    logic             sign;
    logic             sub;
    logic [EXP_W-1:0] exp;
  } ctl_t;

  logic v1, v2, v3, adv;
  assign adv       = ~(v3 & ~out_ready);
  assign in_ready  = adv;
  assign out_valid = v3;

  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

  // ---------------- S1: classify, order by magnitude, align ----------------
  logic [EXP_W-1:0] ea, eb, e_big, e_sml, d;
  logic [MAN_W-1:0] fa, fb;
  logic             sa, sb, a_big, nan_a, nan_b, inf_a, inf_b;
  logic [SW-1:0]    sig_a, sig_b, sig_sml, sml_al;
  logic [2*SW-1:0]  sml_wide;
  ctl_t             c1_n, s1_c, s2_c;
  logic [SW-1:0]    s1_big, s1_sml;
  logic [SW:0]      s2_sum;

  assign ea    = a[W-2 -: EXP_W];
  assign eb    = b[W-2 -: EXP_W];
  assign fa    = a[MAN_W-1:0];
  assign fb    = b[MAN_W-1:0];
  assign sa    = a[W-1];
  assign sb    = b[W-1] ^ ~add_sub;
  assign nan_a = (ea == EXP_MAX) && (fa != '0);
  assign nan_b = (eb == EXP_MAX) && (fb != '0);
  assign inf_a = (ea == EXP_MAX) && (fa == '0);
  assign inf_b = (eb == EXP_MAX) && (fb == '0);
  assign sig_a = {(ea != '0), fa, 3'b000};
  assign sig_b = {(eb != '0), fb, 3'b000};
  assign a_big = a[W-2:0] >= b[W-2:0];

  always_comb begin
    e_big    = a_big ? eff_exp(ea) : eff_exp(eb);
    e_sml    = a_big ? eff_exp(eb) : eff_exp(ea);
    sig_sml  = a_big ? sig_b : sig_a;
    d        = e_big - e_sml;
    sml_wide = {sig_sml, {SW{1'b0}}} >> d;
    // Everything shifted past the window collapses into the sticky bit.
    if (int'(d) >= ALIGN_MAX)
      sml_al = {{(SW-1){1'b0}}, |sig_sml};
    else
      sml_al = sml_wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |sml_wide[SW-1:0]};
    c1_n.nan      = nan_a | nan_b | (inf_a & inf_b & (sa != sb));
    c1_n.inf      = inf_a | inf_b;
    c1_n.inf_sign = inf_a ? sa : sb;
    c1_n.sign     = a_big ? sa : sb;
    c1_n.sub      = sa ^ sb;
    c1_n.exp      = e_big;
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [XW-1:0]    lz, shl, e_n, e_o;
  logic [SW-1:0]    m;
  logic [MAN_W-1:0] frac;
  logic             inexact, sign_r;
  logic [W-1:0]     res_n;
  logic [2:0]       fl_n;
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
  logic             rnd;
  logic [MAN_W+1:0] sig_r;
`endif

  always_comb begin
    lz = XW'(SW);
    for (int i = 0; i < SW; i++)
      if (s2_sum[i]) lz = XW'(SW - 1 - i);
    shl = '0;
    if (s2_sum[SW]) begin
      m   = s2_sum[SW:1] | {{(SW-1){1'b0}}, s2_sum[0]};
      e_n = XW'(s2_c.exp) + ONE;
    end else begin
      // Stop left-normalising at exponent 1 so subnormals come out naturally.
      shl = (lz < XW'(s2_c.exp) - ONE) ? lz : XW'(s2_c.exp) - ONE;
      m   = s2_sum[SW-1:0] << shl;
      e_n = XW'(s2_c.exp) - shl;
    end
    inexact = |m[2:0];
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
    rnd   = m[2] & (m[1] | m[0] | m[3]);
    sig_r = {1'b0, m[SW-1:3]} + (MAN_W+2)'(rnd);
    if (sig_r[MAN_W+1]) begin
      e_o  = e_n + ONE;
      frac = sig_r[MAN_W:1];
    end else begin
      e_o  = sig_r[MAN_W] ? e_n : '0;
      frac = sig_r[MAN_W-1:0];
    end
`else
    e_o  = m[SW-1] ? e_n : '0;
    frac = m[SW-2:3];
`endif
    sign_r = s2_c.sign & ~(s2_c.sub & (s2_sum == '0));
    fl_n   = 3'b000;
    if (s2_c.nan) begin
      res_n = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
      fl_n  = 3'b100;
    end else if (s2_c.inf) begin
      res_n = {s2_c.inf_sign, EXP_MAX, {MAN_W{1'b0}}};
    end else if (e_o >= XW'(EXP_MAX)) begin
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
      res_n = {sign_r, EXP_MAX, {MAN_W{1'b0}}};
`else
      res_n = {sign_r, EXP_MAX - 1'b1, {MAN_W{1'b1}}};
`endif
      fl_n  = 3'b010;
    end else if (e_o == '0 && inexact) begin
      res_n = {sign_r, {(W-1){1'b0}}};
      fl_n  = 3'b001;
    end else begin
      res_n = {sign_r, e_o[EXP_W-1:0], frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      s1_c   <= '0;
      s1_big <= '0;
      s1_sml <= '0;
      s2_c   <= '0;
      s2_sum <= '0;
      res    <= '0;
      flags  <= '0;
    end else if (adv) begin
      v1     <= in_valid;
      s1_c   <= c1_n;
      s1_big <= a_big ? sig_a : sig_b;
      s1_sml <= sml_al;
      v2     <= v1;
      s2_c   <= s1_c;
      s2_sum <= s1_c.sub ? {1'b0, s1_big} - {1'b0, s1_sml} : {1'b0, s1_big} + {1'b0, s1_sml};
      v3     <= v2;
      res    <= res_n;
      flags  <= fl_n;
    end
  end
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// tb/tb_fp_add_sub_pipe.sv - directed bench for fp_add_sub_pipe (single precision)
module tb_fp_add_sub_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        add_sub = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic [2:0]  flags;

  int checks_total = 0;
  int checks_passed = 0;
  int issued, got, stall_hits, extra;

  logic [31:0] st_in  [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0] st_exp [6] = '{32'h40000000, 32'h40800000, 32'h40C00000,
                              32'h41000000, 32'h41200000, 32'h41400000};

`ifdef FP_ADDSUB_ROUND_NEAREST_EN
  localparam logic [31:0] OVF_RES = 32'h7F800000;
  localparam logic [31:0] RND_RES = 32'h3F800002;
`else
  localparam logic [31:0] OVF_RES = 32'h7F7FFFFF;
  localparam logic [31:0] RND_RES = 32'h3F800001;
`endif

  fp_add_sub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .add_sub   (add_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic ts, input logic [31:0] er, input logic [2:0] ef);
    int n;
    @(negedge clk);
    a = ta;
    b = tb;
    add_sub = ts;
    in_valid = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(n), 32'd3);
    check({tag, " res"}, res, er);
    check({tag, " flags"}, {29'b0, flags}, {29'b0, ef});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset res", res, 32'd0);
    check("reset flags", {29'b0, flags}, 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    run_op("1+1",        32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
    run_op("1-1",        32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, 3'b000);
    run_op("max+max",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, OVF_RES,       3'b010);
    run_op("2^127*2",    32'h7F000000, 32'h7F000000, 1'b1, OVF_RES,       3'b010);
    run_op("inf-inf",    32'h7F800000, 32'h7F800000, 1'b0, 32'h7FC00000, 3'b100);
    run_op("nan in",     32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00000, 3'b100);
    run_op("round odd",  32'h3F800001, 32'h33800000, 1'b1, RND_RES,       3'b000);
    run_op("tie even",   32'h3F800000, 32'h33800000, 1'b1, 32'h3F800000, 3'b000);
    run_op("-0+-0",      32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 3'b000);
    run_op("1+(-1)",     32'h3F800000, 32'hBF800000, 1'b1, 32'h00000000, 3'b000);
    run_op("2-1",        32'h40000000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
    run_op("1.5+0.25",   32'h3FC00000, 32'h3E800000, 1'b1, 32'h3FE00000, 3'b000);
    run_op("inf+1",      32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 3'b000);
    run_op("1-inf",      32'h3F800000, 32'h7F800000, 1'b0, 32'hFF800000, 3'b000);
    run_op("sub+sub",    32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 3'b000);
    run_op("minnorm-1",  32'h00800000, 32'h00000001, 1'b0, 32'h007FFFFF, 3'b000);
    run_op("far shift",  32'h3F800000, 32'h00000001, 1'b1, 32'h3F800000, 3'b000);

    // Back-to-back stream with the consumer stalling for cycles 4..8.
    issued = 0;
    got = 0;
    stall_hits = 0;
    add_sub = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 8);
      in_valid = (issued < 6);
      a = st_in[issued % 6];
      b = st_in[issued % 6];
      #1;
      if (out_valid && !out_ready) begin
        stall_hits++;
        check("stall in_ready", 32'(in_ready), 32'd0);
        check("stall hold res", res, st_exp[got]);
      end
      if (out_valid && out_ready) begin
        check("stream res", res, st_exp[got]);
        got++;
      end
      if (in_valid && in_ready) issued++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("stream count", 32'(got), 32'd6);
    check("stream stall cycles", 32'(stall_hits), 32'd5);
    check("stream no duplicates", 32'(extra), 32'd0);

    // Reset with operations in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = st_in[i];
      b = st_in[i];
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset res", res, 32'd0);
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("post reset results", 32'(extra), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
